// File: rtl/ysyx_22050612_dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t            : responder FSM states (IDLE, WAIT, ACCESS, RESP)
//   DEFAULT_BASE_ADDR  : byte address mapped to word 0 of the array
//   index_width()      : word-index width for a given array depth
package ysyx_22050612_dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h8000_0000;

    // A one-word array still needs a 1-bit index port.
    function automatic int index_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ysyx_22050612_dmem_array.sv
// Synchronous single-port RAM, DEPTH x 64 bits, byte-lane write mask,
// registered read data. Contents are never reset.
//   clk    : clock
//   en     : access enable for this cycle
//   wen    : 1 = write the lanes selected by wmask, 0 = read
//   addr   : word index
//   wdata  : write data, lane-aligned
//   wmask  : per-byte write enables
//   rdata  : read word, valid the cycle after a read access, held otherwise
module ysyx_22050612_dmem_array
    import ysyx_22050612_dmem_responder_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = index_width(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          wen,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   wdata,
    input  logic [7:0]    wmask,
    output logic [63:0]   rdata
);

    // One 8-bit-wide array per lane keeps each lane a plain write-first-free
    // RAM with its own write enable.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : lane_g
            logic [7:0] mem_lane [DEPTH];
            logic [7:0] rdata_reg;

            always_ff @(posedge clk) begin
                if (en) begin
                    if (wen && wmask[gi]) begin
                        mem_lane[addr] <= wdata[8*gi +: 8];
                    end
                    if (!wen) begin
                        rdata_reg <= mem_lane[addr];
                    end
                end
            end

            assign rdata[8*gi +: 8] = rdata_reg;
        end
    endgenerate

endmodule

// File: rtl/ysyx_22050612_dmem_responder.sv
// Data-memory responder for the LSU load/store request channel. Accepts one
// request at a time, waits LATENCY cycles, performs a single access on the
// internal RAM and returns read data or a write ack with an out-of-range flag.
//   clk, rst_n                          : clock, async active-low reset
//   req_valid/req_ready                 : request handshake
//   req_wen/req_addr/req_wdata/req_wmask: request fields (sampled at accept)
//   resp_valid/resp_ready               : response handshake
//   resp_rdata                          : loaded word (0 for stores/errors)
//   resp_err                            : address outside the mapped window
module ysyx_22050612_dmem_responder
    import ysyx_22050612_dmem_responder_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          DEPTH     = 4096,
    parameter int          LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW       = index_width(DEPTH);
    localparam logic [63:0] SPAN     = 64'(DEPTH) << 3;
    localparam logic [3:0]  LAT_INIT = 4'(LATENCY);

    state_t      state_reg;
    logic [3:0]  counter_reg;
    logic        wen_reg;
    logic [63:0] addr_reg;
    logic [63:0] wdata_reg;
    logic [7:0]  wmask_reg;
    logic        resp_valid_reg;
    logic        resp_err_reg;
    logic        load_hit_reg;

    logic [63:0]   offset;
    logic          in_range;
    logic [AW-1:0] word_index;
    logic          ram_en;
    logic [63:0]   ram_rdata;

    // Range check on the offset rather than BASE+SPAN so that a window at the
    // top of the address space cannot overflow; addresses below BASE fail the
    // first term and never wrap into the array.
    assign offset     = addr_reg - BASE_ADDR;
    assign in_range   = (addr_reg >= BASE_ADDR) && (offset < SPAN);
    assign word_index = AW'(offset >> 3);
    assign ram_en     = (state_reg == ACCESS) && in_range;

    ysyx_22050612_dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .wen   (wen_reg),
        .addr  (word_index),
        .wdata (wdata_reg),
        .wmask (wmask_reg),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            counter_reg    <= 4'd0;
            wen_reg        <= 1'b0;
            addr_reg       <= 64'd0;
            wdata_reg      <= 64'd0;
            wmask_reg      <= 8'd0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            load_hit_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        wen_reg     <= req_wen;
                        addr_reg    <= req_addr;
                        wdata_reg   <= req_wdata;
                        wmask_reg   <= req_wmask;
                        counter_reg <= LAT_INIT;
                        state_reg   <= (LATENCY > 0) ? WAIT : ACCESS;
                    end
                end
                WAIT: begin
                    counter_reg <= counter_reg - 4'd1;
                    if (counter_reg <= 4'd1) begin
                        state_reg <= ACCESS;
                    end
                end
                ACCESS: begin
                    resp_valid_reg <= 1'b1;
                    resp_err_reg   <= !in_range;
                    load_hit_reg   <= in_range && !wen_reg;
                    state_reg      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = resp_valid_reg;
    assign resp_err   = resp_err_reg;
    // The RAM read register is loaded on the ACCESS edge and only changes on
    // a later access, so it stays stable for the whole RESP phase.
    assign resp_rdata = (resp_valid_reg && load_hit_reg) ? ram_rdata : 64'd0;

endmodule

// File: tb/tb_ysyx_22050612_dmem_responder.sv
module tb_ysyx_22050612_dmem_responder;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          DEPTH = 4096;
    localparam int          LAT   = 2;
    localparam logic [63:0] LAST  = BASE + 64'(DEPTH) * 64'd8 - 64'd8;
    localparam logic [63:0] PAST  = BASE + 64'(DEPTH) * 64'd8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic [7:0]  req_wmask = 8'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ysyx_22050612_dmem_responder #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH),
        .LATENCY   (LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    // Drives one full transaction; inputs change #1 after a rising edge and
    // outputs are sampled there too. lat counts edges from accept to the
    // first resp_valid; request fields are scrambled right after accept.
    task automatic do_req(input logic wen, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [7:0] wmask,
                          output logic [63:0] rdata, output logic err,
                          output int lat);
        int guard;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wen   = ~wen;
        req_addr  = ~addr;
        req_wdata = ~wdata;
        req_wmask = ~wmask;
        lat = 0;
        while (!resp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = resp_rdata;
        err   = resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        $display("txn %s addr=%h wdata=%h wmask=%h -> rdata=%h err=%0d lat=%0d",
                 wen ? "ST" : "LD", addr, wdata, wmask, rdata, err, lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            n_checks++;
            if (resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_valid_in_reset: got %b expected 0", resp_valid);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_req_ready: got %b expected 1", req_ready);
        end
        n_checks++;
        if (resp_rdata !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h expected 0", resp_rdata);
        end
        n_checks++;
        if (resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: got %b expected 0", resp_err);
        end
        repeat (4) begin
            @(posedge clk); #1;
            n_checks++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL idle_quiet: got valid=%b ready=%b expected valid=0 ready=1",
                         resp_valid, req_ready);
            end
        end
    endtask

    task automatic test_store_load();
        logic [63:0] rd;
        logic        er;
        int          lat;
        do_req(1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, rd, er, lat);
        n_checks++;
        if (lat !== LAT + 1) begin
            n_fail++;
            $display("FAIL store_latency: got %0d expected %0d", lat, LAT + 1);
        end
        n_checks++;
        if (er !== 1'b0 || rd !== 64'd0) begin
            n_fail++;
            $display("FAIL store_ack: got err=%b rdata=%h expected err=0 rdata=0", er, rd);
        end
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL store_handshake: got valid=%b ready=%b expected 0/1",
                     resp_valid, req_ready);
        end
        do_req(1'b0, 64'h8000_0010, 64'd0, 8'h00, rd, er, lat);
        n_checks++;
        if (rd !== 64'h1122_3344_5566_7788) begin
            n_fail++;
            $display("FAIL load_data: got %h expected 1122334455667788", rd);
        end
        n_checks++;
        if (lat !== LAT + 1 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL load_lat_err: got lat=%0d err=%b expected lat=%0d err=0",
                     lat, er, LAT + 1);
        end
    endtask

    task automatic test_byte_mask();
        logic [63:0] rd;
        logic        er;
        int          lat;
        do_req(1'b1, 64'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, rd, er, lat);
        do_req(1'b0, 64'h8000_0010, 64'd0, 8'h00, rd, er, lat);
        n_checks++;
        if (rd !== 64'h1122_3344_AAAA_AAAA) begin
            n_fail++;
            $display("FAIL mask_low_lanes: got %h expected 11223344aaaaaaaa", rd);
        end
        // An empty mask is acknowledged but leaves the word untouched.
        do_req(1'b1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, rd, er, lat);
        n_checks++;
        if (er !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_zero_err: got %b expected 0", er);
        end
        do_req(1'b0, 64'h8000_0017, 64'd0, 8'h00, rd, er, lat);
        n_checks++;
        if (rd !== 64'h1122_3344_AAAA_AAAA) begin
            n_fail++;
            $display("FAIL mask_zero_data: got %h expected 11223344aaaaaaaa", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] rd;
        logic        er;
        int          lat;
        do_req(1'b1, 64'h8000_0008, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, rd, er, lat);
        do_req(1'b0, 64'h8000_0008, 64'd0, 8'h00, rd, er, lat);
        n_checks++;
        if (rd !== 64'hDEAD_BEEF_CAFE_F00D) begin
            n_fail++;
            $display("FAIL raw_data: got %h expected deadbeefcafef00d", rd);
        end
        do_req(1'b1, 64'h8000_0008, 64'h0000_0000_0000_0000, 8'hF0, rd, er, lat);
        do_req(1'b0, 64'h8000_0008, 64'd0, 8'h00, rd, er, lat);
        n_checks++;
        if (rd !== 64'h0000_0000_CAFE_F00D) begin
            n_fail++;
            $display("FAIL raw_high_lanes: got %h expected 00000000cafef00d", rd);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] rd;
        logic        er;
        int          lat;
        int          guard;
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = 64'h8000_0010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        guard = 0;
        while (!resp_valid && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        n_checks++;
        if (resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_timeout: got valid=%b expected 1", resp_valid);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 64'h1122_3344_AAAA_AAAA ||
                resp_err !== 1'b0 || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%b rdata=%h err=%b ready=%b expected 1/11223344aaaaaaaa/0/0",
                         i, resp_valid, resp_rdata, resp_err, req_ready);
            end
            // Store attempt while busy must be ignored.
            if (i == 2) begin
                req_valid = 1'b1;
                req_wen   = 1'b1;
                req_addr  = 64'h8000_0010;
                req_wdata = 64'd0;
                req_wmask = 8'hFF;
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got valid=%b ready=%b expected 0/1", resp_valid, req_ready);
        end
        $display("txn LD addr=%h held 5 cycles under backpressure", 64'h8000_0010);
        do_req(1'b0, 64'h8000_0010, 64'd0, 8'h00, rd, er, lat);
        n_checks++;
        if (rd !== 64'h1122_3344_AAAA_AAAA) begin
            n_fail++;
            $display("FAIL bp_no_accept: got %h expected 11223344aaaaaaaa", rd);
        end
    endtask

    task automatic test_range_errors();
        logic [63:0] rd;
        logic        er;
        int          lat;
        do_req(1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, rd, er, lat);
        n_checks++;
        if (er !== 1'b1 || rd !== 64'd0) begin
            n_fail++;
            $display("FAIL below_base: got err=%b rdata=%h expected err=1 rdata=0", er, rd);
        end
        do_req(1'b1, LAST, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, rd, er, lat);
        n_checks++;
        if (er !== 1'b0) begin
            n_fail++;
            $display("FAIL last_word_err: got %b expected 0", er);
        end
        do_req(1'b1, PAST, 64'h0000_0000_0000_0000, 8'hFF, rd, er, lat);
        n_checks++;
        if (er !== 1'b1 || rd !== 64'd0 || lat !== LAT + 1) begin
            n_fail++;
            $display("FAIL past_end_store: got err=%b rdata=%h lat=%0d expected err=1 rdata=0 lat=%0d",
                     er, rd, lat, LAT + 1);
        end
        do_req(1'b0, LAST + 64'd7, 64'd0, 8'h00, rd, er, lat);
        n_checks++;
        if (er !== 1'b0 || rd !== 64'hA5A5_5A5A_0F0F_F0F0) begin
            n_fail++;
            $display("FAIL last_word_readback: got err=%b rdata=%h expected err=0 rdata=a5a55a5a0f0ff0f0",
                     er, rd);
        end
        do_req(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 8'h00, rd, er, lat);
        n_checks++;
        if (er !== 1'b1 || rd !== 64'd0) begin
            n_fail++;
            $display("FAIL top_of_space: got err=%b rdata=%h expected err=1 rdata=0", er, rd);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [63:0] rd;
        logic        er;
        int          lat;
        do_req(1'b1, 64'h8000_0020, 64'h0123_4567_89AB_CDEF, 8'hFF, rd, er, lat);
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = 64'h8000_0020;
        req_wdata = 64'hFEDC_BA98_7654_3210;
        req_wmask = 8'hFF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_wait_abort: got valid=%b ready=%b expected 0/1", resp_valid, req_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("txn ST addr=%h abandoned by reset during wait", 64'h8000_0020);
        do_req(1'b0, 64'h8000_0020, 64'd0, 8'h00, rd, er, lat);
        n_checks++;
        if (rd !== 64'h0123_4567_89AB_CDEF) begin
            n_fail++;
            $display("FAIL rst_wait_no_write: got %h expected 0123456789abcdef", rd);
        end
    endtask

    task automatic test_reset_mid_resp();
        int guard;
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = 64'h8000_0020;
        @(posedge clk); #1;
        req_valid = 1'b0;
        guard = 0;
        while (!resp_valid && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        n_checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 64'h0123_4567_89AB_CDEF) begin
            n_fail++;
            $display("FAIL rst_resp_pre: got valid=%b rdata=%h expected 1/0123456789abcdef",
                     resp_valid, resp_rdata);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 64'd0 || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_resp_drop: got valid=%b rdata=%h err=%b expected 0/0/0",
                     resp_valid, resp_rdata, resp_err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("txn LD addr=%h abandoned by reset during response", 64'h8000_0020);
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_mask();
        test_back_to_back();
        test_backpressure();
        test_range_errors();
        test_reset_mid_wait();
        test_reset_mid_resp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
